// File: rtl/lbirow_pkg.sv
// Shared constants, state type and LFSR step function for the Lbirow row-message feeder.
package lbirow_pkg;

  localparam int WORD_W = 56;
  localparam int BEATS  = 15;
  localparam int MSG_W  = 840;
  localparam int RAND_W = 96;

  // Feedback taps of the 96-bit random word generator.
  localparam int TAP_A = 95;
  localparam int TAP_B = 93;
  localparam int TAP_C = 48;
  localparam int TAP_D = 46;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One left shift of the LFSR; the XOR of the taps enters at bit 0.
  function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] s);
    lfsr_next = {s[RAND_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/lbirow_lfsr96.sv
// 96-bit Fibonacci LFSR: loads SEED on reset, advances one step when step_i is high.
module lbirow_lfsr96
  import lbirow_pkg::*;
#(
  parameter logic [RAND_W-1:0] SEED = 96'h1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  output logic [RAND_W-1:0] state_o
);

  logic [RAND_W-1:0] state_q;
  logic [RAND_W-1:0] state_d;

  // Next LFSR value: advance only when a message is issued.
  always_comb begin
    if (step_i) begin
      state_d = lfsr_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lbirow_feeder.sv
// Lbirow row-message feeder: packs 15 x 56-bit beats MSB-first into an 840-bit
// message and issues it with a one-cycle valid strobe and a fresh random word.
module lbirow_feeder
  import lbirow_pkg::*;
#(
  parameter logic [RAND_W-1:0] LFSR_SEED = 96'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              stop,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              hold,
  output logic [MSG_W-1:0]  msg_out,
  output logic              valid,
  output logic              start,
  output logic [RAND_W-1:0] randomout,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       msg_count
);

  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  state_e             state_q, state_d;
  logic [3:0]         beat_cnt_q, beat_cnt_d;
  logic               full_q, full_d;
  logic [MSG_W-1:0]   buf_q, buf_d;
  logic               first_pending_q, first_pending_d;
  logic               stop_pend_q, stop_pend_d;
  logic               frame_err_q, frame_err_d;
  logic [15:0]        msg_count_q, msg_count_d;
  logic [MSG_W-1:0]   msg_out_q, msg_out_d;
  logic               valid_q, valid_d;
  logic               start_q, start_d;
  logic               issue_s;
  logic               leave_s;
  logic               accept_s;
  logic               in_ready_s;

  // Ready depends only on registered state so hold never reaches in_ready.
  assign in_ready_s = (state_q == RUN) && !full_q;

  // Next-state, packing, framing and issue logic.
  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    full_d          = full_q;
    buf_d           = buf_q;
    first_pending_d = first_pending_q;
    stop_pend_d     = stop_pend_q;
    frame_err_d     = frame_err_q;
    msg_count_d     = msg_count_q;
    msg_out_d       = msg_out_q;
    valid_d         = 1'b0;
    start_d         = 1'b0;
    issue_s         = 1'b0;
    leave_s         = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d         = RUN;
          frame_err_d     = 1'b0;
          msg_count_d     = 16'd0;
          first_pending_d = 1'b1;
          stop_pend_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Leave only once no partial or unissued message remains.
        if ((stop || stop_pend_q) && (beat_cnt_q == 4'd0) && !full_q) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
          leave_s     = 1'b1;
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A beat arriving on the cycle the frame closes is dropped.
    accept_s = in_valid && in_ready_s && !leave_s;

    if (accept_s) begin
      if (beat_cnt_q == LAST_BEAT) begin
        buf_d[WORD_W-1:0] = in_data;
        full_d            = 1'b1;
        beat_cnt_d        = 4'd0;
        if (!in_last) begin
          frame_err_d = 1'b1;
        end else begin
          frame_err_d = frame_err_q;
        end
      end else if (in_last) begin
        // Early last: throw the partial message away and restart packing.
        frame_err_d = 1'b1;
        beat_cnt_d  = 4'd0;
      end else begin
        for (int k = 0; k < BEATS - 1; k++) begin
          if (beat_cnt_q == 4'(k)) begin
            buf_d[MSG_W-1-k*WORD_W -: WORD_W] = in_data;
          end else begin
            buf_d = buf_d;
          end
        end
        beat_cnt_d = beat_cnt_q + 4'd1;
      end
    end else begin
      beat_cnt_d = beat_cnt_d;
    end

    if (full_q && !hold) begin
      issue_s         = 1'b1;
      msg_out_d       = buf_q;
      valid_d         = 1'b1;
      start_d         = first_pending_q;
      first_pending_d = 1'b0;
      full_d          = 1'b0;
      if (msg_count_q == 16'hFFFF) begin
        msg_count_d = msg_count_q;
      end else begin
        msg_count_d = msg_count_q + 16'd1;
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  // State, packing buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      beat_cnt_q      <= 4'd0;
      full_q          <= 1'b0;
      buf_q           <= '0;
      first_pending_q <= 1'b0;
      stop_pend_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      msg_count_q     <= 16'd0;
      msg_out_q       <= '0;
      valid_q         <= 1'b0;
      start_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      full_q          <= full_d;
      buf_q           <= buf_d;
      first_pending_q <= first_pending_d;
      stop_pend_q     <= stop_pend_d;
      frame_err_q     <= frame_err_d;
      msg_count_q     <= msg_count_d;
      msg_out_q       <= msg_out_d;
      valid_q         <= valid_d;
      start_q         <= start_d;
    end
  end

  lbirow_lfsr96 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .step_i (issue_s),
    .state_o(randomout)
  );

  assign in_ready  = in_ready_s;
  assign busy      = (state_q == RUN);
  assign msg_out   = msg_out_q;
  assign valid     = valid_q;
  assign start     = start_q;
  assign frame_err = frame_err_q;
  assign msg_count = msg_count_q;

endmodule

// File: tb/tb_lbirow_feeder.sv
// Directed self-checking bench for lbirow_feeder.
module tb_lbirow_feeder;

  logic          clk = 1'b0;
  logic          rst;
  logic          go, stop, in_valid, in_last, hold;
  logic [55:0]   in_data;
  logic          in_ready, valid, start, busy, frame_err;
  logic [839:0]  msg_out;
  logic [95:0]   randomout;
  logic [15:0]   msg_count;

  int nvec = 0;
  int nerr = 0;

  lbirow_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .stop     (stop),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .hold     (hold),
    .msg_out  (msg_out),
    .valid    (valid),
    .start    (start),
    .randomout(randomout),
    .busy     (busy),
    .frame_err(frame_err),
    .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare each 56-bit word of msg_out against base + k*step.
  task automatic chk_msg(input string tag, input logic [55:0] base, input logic [55:0] step);
    logic [55:0] w;
    logic [55:0] e;
    for (int k = 0; k < 15; k++) begin
      w = msg_out[839-k*56 -: 56];
      e = base + 56'(k) * step;
      chk($sformatf("%s_w%0d", tag, k), {40'd0, w}, {40'd0, e});
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one beat, wait for in_ready, return at the negedge after acceptance.
  task automatic beat(input logic [55:0] d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("rdy_wait", {95'd0, guard < 50}, 96'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  initial begin
    rst = 1'b0; go = 1'b0; stop = 1'b0; hold = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 56'd0;
    tick(); tick();

    // Reset values
    chk("rst_valid", {95'd0, valid}, 96'd0);
    chk("rst_start", {95'd0, start}, 96'd0);
    chk("rst_msg0", {95'd0, |msg_out}, 96'd0);
    chk("rst_rand", randomout, 96'h1);
    chk("rst_rdy", {95'd0, in_ready}, 96'd0);
    chk("rst_busy", {95'd0, busy}, 96'd0);
    rst = 1'b1;
    tick();

    // First message: beats 1..15
    pulse_go();
    chk("go_busy", {95'd0, busy}, 96'd1);
    for (int k = 0; k < 15; k++) beat(56'(k + 1), k == 14);
    chk("m1_pre_valid", {95'd0, valid}, 96'd0);
    chk("m1_bubble", {95'd0, in_ready}, 96'd0);
    tick();
    chk("m1_valid", {95'd0, valid}, 96'd1);
    chk("m1_start", {95'd0, start}, 96'd1);
    chk("m1_rand", randomout, 96'h2);
    chk("m1_cnt", {80'd0, msg_count}, 96'd1);
    chk("m1_rdy", {95'd0, in_ready}, 96'd1);
    chk_msg("m1", 56'h1, 56'h1);
    tick();
    chk("m1_valid_off", {95'd0, valid}, 96'd0);

    // Second message
    for (int k = 0; k < 15; k++) beat(56'h100 + 56'(k), k == 14);
    chk("m2_bubble", {95'd0, in_ready}, 96'd0);
    tick();
    chk("m2_valid", {95'd0, valid}, 96'd1);
    chk("m2_start", {95'd0, start}, 96'd0);
    chk("m2_rand", randomout, 96'h4);
    chk("m2_cnt", {80'd0, msg_count}, 96'd2);
    chk("m2_rdy", {95'd0, in_ready}, 96'd1);
    chk_msg("m2", 56'h100, 56'h1);

    // Hold before the final beat, held for 5 cycles
    for (int k = 0; k < 14; k++) beat(56'h200 + 56'(k), 1'b0);
    hold = 1'b1;
    beat(56'h20E, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {95'd0, valid}, 96'd0);
      chk("hold_rdy", {95'd0, in_ready}, 96'd0);
      tick();
    end
    hold = 1'b0;
    tick();
    chk("m3_valid", {95'd0, valid}, 96'd1);
    chk("m3_rand", randomout, 96'h8);
    chk("m3_cnt", {80'd0, msg_count}, 96'd3);
    chk_msg("m3", 56'h200, 56'h1);

    // Early in_last on beat 5
    for (int k = 0; k < 6; k++) beat(56'h9000 + 56'(k), k == 5);
    chk("early_err", {95'd0, frame_err}, 96'd1);
    tick();
    chk("early_novalid", {95'd0, valid}, 96'd0);
    chk("early_cnt", {80'd0, msg_count}, 96'd3);
    for (int k = 0; k < 15; k++) beat(56'h300 + 56'(k), k == 14);
    tick();
    chk("m4_valid", {95'd0, valid}, 96'd1);
    chk("m4_err_sticky", {95'd0, frame_err}, 96'd1);
    chk("m4_rand", randomout, 96'h10);
    chk_msg("m4", 56'h300, 56'h1);

    // Asynchronous reset after 7 beats
    for (int k = 0; k < 7; k++) beat(56'h77, 1'b0);
    rst = 1'b0;
    #1;
    chk("ar_valid", {95'd0, valid}, 96'd0);
    chk("ar_busy", {95'd0, busy}, 96'd0);
    chk("ar_rdy", {95'd0, in_ready}, 96'd0);
    chk("ar_rand", randomout, 96'h1);
    chk("ar_msg0", {95'd0, |msg_out}, 96'd0);
    chk("ar_err", {95'd0, frame_err}, 96'd0);
    chk("ar_cnt", {80'd0, msg_count}, 96'd0);
    tick();
    rst = 1'b1;
    tick();
    pulse_go();
    for (int k = 0; k < 15; k++) beat(56'hAA, k == 14);
    tick();
    chk("aa_valid", {95'd0, valid}, 96'd1);
    chk("aa_start", {95'd0, start}, 96'd1);
    chk("aa_rand", randomout, 96'h2);
    chk("aa_cnt", {80'd0, msg_count}, 96'd1);
    chk_msg("aa", 56'hAA, 56'h0);

    // Stop after 3 beats: frame closes only after the message issues
    for (int k = 0; k < 3; k++) beat(56'h400 + 56'(k), 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", {95'd0, busy}, 96'd1);
    for (int k = 3; k < 15; k++) beat(56'h400 + 56'(k), k == 14);
    chk("stop_busy_full", {95'd0, busy}, 96'd1);
    tick();
    chk("m6_valid", {95'd0, valid}, 96'd1);
    chk("m6_busy", {95'd0, busy}, 96'd1);
    chk("m6_rand", randomout, 96'h4);
    chk_msg("m6", 56'h400, 56'h1);
    tick();
    chk("stop_idle", {95'd0, busy}, 96'd0);
    chk("stop_rdy", {95'd0, in_ready}, 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lbirow_feeder.md
Name: lbirow_feeder

Overview:
- Transmit side of the Lbirow row-message interface.
- Accepts a narrow beat stream from the row-data source and packs 15 beats of 56 bits into one 840-bit message.
- Drives the Lbirow input port group: msg, valid, start and a 96-bit random word from an internal LFSR.
- Sits between the lattice row buffer / DMA and the Lbirow pipeline.

Parameters:
- WORD_W, 56, input beat width.
- BEATS, 15, beats per message (WORD_W*BEATS = MSG_W).
- MSG_W, 840, message width.
- RAND_W, 96, random word width.
- LFSR_SEED, 96'h1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  start a frame (sampled in IDLE).
- stop  in  1  end the frame (sampled in RUN).
- in_data  in  56  beat payload.
- in_valid  in  1  beat valid.
- in_last  in  1  marks the final beat of a message.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- hold  in  1  downstream stall; no message is issued while high.
- msg_out  out  840  message to Lbirow.
- valid  out  1  one-cycle message strobe.
- start  out  1  first message of a frame.
- randomout  out  96  random word qualified by valid.
- busy  out  1  state == RUN.
- frame_err  out  1  sticky framing error.
- msg_count  out  16  messages issued in the current frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat_cnt=0, full=0.
  - msg_out=0, valid=0, start=0, randomout=LFSR_SEED.
  - frame_err=0, msg_count=0, in_ready=0.
  - Any partial or full message is discarded.
- States:
  - IDLE: go -> RUN; clears frame_err and msg_count; sets first_pending. stop is ignored.
  - RUN: go is ignored. stop while beat_cnt==0 && !full -> IDLE. Otherwise stop is latched and the transition happens once those conditions hold; the pending message is still issued.
- Accept:
  - in_ready = RUN && !full (registered terms only; no combinational path from hold).
  - Beat k (k = beat_cnt) is written to buffer bits [MSG_W-1-k*WORD_W -: WORD_W], i.e. beat 0 is MSB-first.
  - beat_cnt increments; on k==BEATS-1, full<=1 and beat_cnt<=0.
- Framing:
  - in_last must equal (k==BEATS-1).
  - in_last early: frame_err<=1, partial buffer discarded, beat_cnt<=0.
  - in_last missing on beat 14: frame_err<=1, message still completes.
- Issue:
  - When full && !hold at a clock edge: msg_out<=buffer, valid<=1, full<=0, LFSR steps and randomout<=next value.
  - start<=first_pending, then first_pending<=0.
  - msg_count increments, saturating at 16'hFFFF.
  - Otherwise valid<=0 and start<=0. msg_out holds its last value.
- Latency:
  - valid rises at the edge after the accepting edge of the final beat (hold=0).
  - One bubble cycle on in_ready per message, so peak rate is 1 message per 16 cycles.
- LFSR: shift left; new bit0 = s[95]^s[93]^s[48]^s[46]. It steps only on issue and is not reseeded by go.
- Simultaneous events:
  - hold=1 with full: message waits and valid=0.
  - stop with a full buffer: issue first, then IDLE.

Decomposition:
- lbirow_pkg:
  - Constants MSG_W, WORD_W, BEATS, RAND_W and the LFSR tap indices.
  - State typedef {IDLE, RUN}.
- Sub-module lbirow_lfsr96: load-on-reset, step-enable, 96-bit output.

Test Plan:
- Reset -> valid=0, start=0, msg_out=0, randomout=96'h1, in_ready=0, busy=0.
- go, 15 beats in_data=k+1 (k=0..14), in_last on beat 14 -> one cycle later: valid=1, start=1, msg_out={56'h1,56'h2,...,56'hF}, randomout=96'h2, msg_count=1.
- Second 15-beat message -> valid=1, start=0, randomout=96'h4, msg_count=2; in_ready=0 for exactly one cycle between messages.
- hold=1 before beat 14, held 5 cycles -> valid=0 and in_ready=0 throughout; hold drop -> valid one cycle later with correct msg_out.
- in_last on beat 5 -> frame_err=1, no valid; next 15 beats (last on 14) -> clean message issued; frame_err stays 1 until the next go.
- rst low after 7 beats -> all outputs at reset values; go plus 15 beats of 56'hAA -> msg_out contains only 56'hAA words. Separately, stop after 3 beats -> busy stays 1 until the message completes and issues, then IDLE.
